// File: rtl/input_port_buffer.sv
// Router input port: first-word fall-through flit FIFO with XY route computation on the head flit.
// Refused writes (FIFO full) are signalled with a one-cycle drop pulse.
module input_port_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int MY_X   = 2,
    parameter int MY_Y   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              buffer_full_o,
    output logic [4:0]        request_o,
    output logic [7:0]        packet_addr_o,
    input  logic              grant_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              drop_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [3:0]    MX       = 4'(MY_X);
    localparam logic [3:0]    MYY      = 4'(MY_Y);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              wr_acc;
    logic              pop;
    logic [3:0]        head_x;
    logic [3:0]        head_y;

    assign buffer_full_o = (count == CNT_FULL);
    assign valid_o       = (count != '0);
    assign wr_acc        = write_en_i && !buffer_full_o;
    assign pop           = grant_i && valid_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            drop_o <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_acc, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            drop_o <= write_en_i && buffer_full_o;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= data_i;
        end
    end

    assign data_o        = mem[rd_ptr];
    assign packet_addr_o = data_o[7:0];
    assign head_x        = packet_addr_o[7:4];
    assign head_y        = packet_addr_o[3:0];

    // XY routing: resolve X first, then Y; bit order is N,S,E,W,L.
    always_comb begin
        request_o = 5'b00000;
        if (valid_o) begin
            if (head_x > MX) begin
                request_o = 5'b00100;
            end else if (head_x < MX) begin
                request_o = 5'b01000;
            end else if (head_y > MYY) begin
                request_o = 5'b00001;
            end else if (head_y < MYY) begin
                request_o = 5'b00010;
            end else begin
                request_o = 5'b10000;
            end
        end
    end

endmodule

// File: tb/tb_input_port_buffer.sv
// Self-checking bench for input_port_buffer: directed scenarios plus randomized traffic
// compared against a queue-based model of the FIFO and the XY routing rule.
module tb_input_port_buffer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int MY_X   = 2;
    localparam int MY_Y   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              write_en_i;
    logic [DATA_W-1:0] data_i;
    logic              buffer_full_o;
    logic [4:0]        request_o;
    logic [7:0]        packet_addr_o;
    logic              grant_i;
    logic              valid_o;
    logic [DATA_W-1:0] data_o;
    logic              drop_o;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] model_q[$];
    logic              model_drop;

    input_port_buffer #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .MY_X  (MY_X),
        .MY_Y  (MY_Y)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .write_en_i   (write_en_i),
        .data_i       (data_i),
        .buffer_full_o(buffer_full_o),
        .request_o    (request_o),
        .packet_addr_o(packet_addr_o),
        .grant_i      (grant_i),
        .valid_o      (valid_o),
        .data_o       (data_o),
        .drop_o       (drop_o)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] route(input logic [7:0] a);
        int x;
        int y;
        x = int'(a[7:4]);
        y = int'(a[3:0]);
        if (x > MY_X) return 5'b00100;
        if (x < MY_X) return 5'b01000;
        if (y > MY_Y) return 5'b00001;
        if (y < MY_Y) return 5'b00010;
        return 5'b10000;
    endfunction

    function automatic logic [DATA_W-1:0] mk_flit(input logic [7:0] a);
        return {(DATA_W-8)'($urandom), a};
    endfunction

    // One clock: drive inputs, update the model at the edge, return at the falling edge.
    task automatic drive_cycle(input logic r, input logic we, input logic [DATA_W-1:0] d,
                               input logic g);
        bit was_full;
        rst        = r;
        write_en_i = we;
        data_i     = d;
        grant_i    = g;
        @(posedge clk);
        if (r) begin
            model_q.delete();
            model_drop = 1'b0;
        end else begin
            was_full   = (model_q.size() == DEPTH);
            model_drop = we && was_full;
            if (g && model_q.size() > 0) void'(model_q.pop_front());
            if (we && !was_full) model_q.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive_cycle(1'b1, 1'b0, '0, 1'b0);
        drive_cycle(1'b0, 1'b0, '0, 1'b0);
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid: got %b expected 0", valid_o);
        end
        checks++;
        if (buffer_full_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_full: got %b expected 0", buffer_full_o);
        end
        checks++;
        if (request_o !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_request: got %b expected 00000", request_o);
        end
        checks++;
        if (drop_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_drop: got %b expected 0", drop_o);
        end
    endtask

    task automatic test_single_east();
        logic [DATA_W-1:0] f;
        drive_cycle(1'b1, 1'b0, '0, 1'b0);
        f = mk_flit(8'h52);
        drive_cycle(1'b0, 1'b1, f, 1'b0);
        checks++;
        if (valid_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL east_valid: got %b expected 1", valid_o);
        end
        checks++;
        if (request_o !== 5'b00100) begin
            errors++;
            $display("[TB] FAIL east_request: got %b expected 00100", request_o);
        end
        checks++;
        if (packet_addr_o !== 8'h52) begin
            errors++;
            $display("[TB] FAIL east_addr: got %h expected 52", packet_addr_o);
        end
        checks++;
        if (data_o !== f) begin
            errors++;
            $display("[TB] FAIL east_data: got %h expected %h", data_o, f);
        end
    endtask

    task automatic test_route_sequence();
        logic [7:0] heads [4];
        logic [4:0] exp_req [5];
        heads   = '{8'h22, 8'h23, 8'h21, 8'h12};
        exp_req = '{5'b10000, 5'b00001, 5'b00010, 5'b01000, 5'b00000};
        drive_cycle(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive_cycle(1'b0, 1'b1, mk_flit(heads[i]), 1'b1);
            else       drive_cycle(1'b0, 1'b0, '0, 1'b1);
            checks++;
            if (request_o !== exp_req[i]) begin
                errors++;
                $display("[TB] FAIL route_seq[%0d]: got %b expected %b", i, request_o, exp_req[i]);
            end
        end
    endtask

    task automatic test_full_drop();
        logic [DATA_W-1:0] first;
        drive_cycle(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < DEPTH; i++) drive_cycle(1'b0, 1'b1, mk_flit(8'h30 + 8'(i)), 1'b0);
        first = model_q[0];
        checks++;
        if (buffer_full_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_after_fill: got %b expected 1", buffer_full_o);
        end
        drive_cycle(1'b0, 1'b1, mk_flit(8'h55), 1'b0);
        checks++;
        if (drop_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL drop_pulse: got %b expected 1", drop_o);
        end
        checks++;
        if (buffer_full_o !== 1'b1 || data_o !== first) begin
            errors++;
            $display("[TB] FAIL drop_unchanged: full=%b head=%h expected full=1 head=%h",
                     buffer_full_o, data_o, first);
        end
        drive_cycle(1'b0, 1'b0, '0, 1'b0);
        checks++;
        if (drop_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drop_one_cycle: got %b expected 0", drop_o);
        end
        // Drain and confirm the stored order is intact after the refused write.
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (data_o !== model_q[0]) begin
                errors++;
                $display("[TB] FAIL drop_drain[%0d]: got %h expected %h", i, data_o, model_q[0]);
            end
            drive_cycle(1'b0, 1'b0, '0, 1'b1);
        end
    endtask

    task automatic test_full_write_grant();
        logic [DATA_W-1:0] second;
        drive_cycle(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < DEPTH; i++) drive_cycle(1'b0, 1'b1, mk_flit(8'h40 + 8'(i)), 1'b0);
        second = model_q[1];
        drive_cycle(1'b0, 1'b1, mk_flit(8'h66), 1'b1);
        checks++;
        if (drop_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fullwg_drop: got %b expected 1", drop_o);
        end
        checks++;
        if (buffer_full_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fullwg_full: got %b expected 0", buffer_full_o);
        end
        checks++;
        if (data_o !== second) begin
            errors++;
            $display("[TB] FAIL fullwg_head: got %h expected %h", data_o, second);
        end
    endtask

    task automatic test_wrap_interleave();
        drive_cycle(1'b1, 1'b0, '0, 1'b0);
        drive_cycle(1'b0, 1'b1, mk_flit(8'(($urandom_range(0, 4) << 4) | $urandom_range(0, 4))), 1'b0);
        drive_cycle(1'b0, 1'b1, mk_flit(8'(($urandom_range(0, 4) << 4) | $urandom_range(0, 4))), 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b0, 1'b1, mk_flit(8'(($urandom_range(0, 4) << 4) | $urandom_range(0, 4))), 1'b1);
            checks++;
            if (valid_o !== 1'b1 || data_o !== model_q[0] || request_o !== route(model_q[0][7:0])) begin
                errors++;
                $display("[TB] FAIL wrap[%0d]: valid=%b data=%h req=%b expected 1 %h %b", i,
                         valid_o, data_o, request_o, model_q[0], route(model_q[0][7:0]));
            end
            checks++;
            if (buffer_full_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL wrap_count[%0d]: full=%b expected 0", i, buffer_full_o);
            end
        end
        drive_cycle(1'b0, 1'b0, '0, 1'b1);
        drive_cycle(1'b0, 1'b0, '0, 1'b1);
        drive_cycle(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (valid_o !== 1'b0 || buffer_full_o !== 1'b0 || request_o !== 5'b0) begin
            errors++;
            $display("[TB] FAIL grant_empty: valid=%b full=%b req=%b expected 0 0 00000",
                     valid_o, buffer_full_o, request_o);
        end
        // A grant on empty must not underflow: one write then shows exactly one flit.
        drive_cycle(1'b0, 1'b1, mk_flit(8'h22), 1'b0);
        drive_cycle(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL empty_no_underflow: valid=%b expected 0", valid_o);
        end
    endtask

    task automatic test_random();
        logic we;
        logic g;
        drive_cycle(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            we = ($urandom_range(0, 99) < 60);
            g  = ($urandom_range(0, 99) < 45);
            drive_cycle(1'b0, we,
                        mk_flit(8'(($urandom_range(0, 4) << 4) | $urandom_range(0, 4))), g);
            checks++;
            if (valid_o !== (model_q.size() != 0) || buffer_full_o !== (model_q.size() == DEPTH)
                || drop_o !== model_drop) begin
                errors++;
                $display("[TB] FAIL rand_flags[%0d]: valid=%b full=%b drop=%b expected %b %b %b",
                         i, valid_o, buffer_full_o, drop_o, model_q.size() != 0,
                         model_q.size() == DEPTH, model_drop);
            end
            if (model_q.size() != 0) begin
                checks++;
                if (data_o !== model_q[0] || packet_addr_o !== model_q[0][7:0]
                    || request_o !== route(model_q[0][7:0]) || !$onehot(request_o)) begin
                    errors++;
                    $display("[TB] FAIL rand_head[%0d]: data=%h req=%b expected %h %b", i,
                             data_o, request_o, model_q[0], route(model_q[0][7:0]));
                end
            end else begin
                checks++;
                if (request_o !== 5'b0) begin
                    errors++;
                    $display("[TB] FAIL rand_req_empty[%0d]: got %b expected 00000", i, request_o);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        drive_cycle(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, mk_flit(8'h31), 1'b0);
        drive_cycle(1'b1, 1'b1, mk_flit(8'h13), 1'b1);
        checks++;
        if (valid_o !== 1'b0 || request_o !== 5'b0 || buffer_full_o !== 1'b0 || drop_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid: valid=%b req=%b full=%b drop=%b expected 0 00000 0 0",
                     valid_o, request_o, buffer_full_o, drop_o);
        end
        drive_cycle(1'b0, 1'b0, '0, 1'b0);
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_hold: valid=%b expected 0", valid_o);
        end
    endtask

    initial begin
        rst        = 1'b1;
        write_en_i = 1'b0;
        data_i     = '0;
        grant_i    = 1'b0;
        model_drop = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_east();
        test_route_sequence();
        test_full_drop();
        test_full_write_grant();
        test_wrap_interleave();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/input_port_buffer.md
INPUT_PORT_BUFFER -- requirements
Module: input_port_buffer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning flit width; destination address is bits [7:0] (X = [7:4], Y = [3:0]).
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning FIFO entries (power of two, >= 2).
REQ-003 The block SHALL have parameter MY_X, default 2, meaning this router's X coordinate (4 bits).
REQ-004 The block SHALL have parameter MY_Y, default 2, meaning this router's Y coordinate (4 bits).
REQ-005 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, meaning reset, synchronous and active-high.
REQ-007 The block SHALL have port write_en_i, input, 1 bit, meaning the upstream link presents a flit.
REQ-008 The block SHALL have port data_i, input, DATA_W bits, meaning the upstream flit.
REQ-009 The block SHALL have port buffer_full_o, output, 1 bit, meaning the FIFO holds DEPTH flits; fed to the upstream router's allocator full input.
REQ-010 The block SHALL have port request_o, output, 5 bits, meaning a one-hot output-port request (bit0 N, bit1 S, bit2 E, bit3 W, bit4 L) to the output arbiters.
REQ-011 The block SHALL have port packet_addr_o, output, 8 bits, meaning the head flit's data[7:0].
REQ-012 The block SHALL have port grant_i, input, 1 bit, meaning the switch allocator granted this input this cycle.
REQ-013 The block SHALL have port valid_o, output, 1 bit, meaning the FIFO is non-empty.
REQ-014 The block SHALL have port data_o, output, DATA_W bits, meaning the head flit (first-word fall-through).
REQ-015 The block SHALL have port drop_o, output, 1 bit, meaning a one-cycle pulse when a write was refused.

Function
REQ-016 Count SHALL range 0..DEPTH; buffer_full_o = (count == DEPTH) and valid_o = (count != 0), both decoded from registered state only.
REQ-017 Write SHALL be accepted iff write_en_i && !buffer_full_o; the flit is stored at the write pointer and the pointer advances modulo DEPTH.
REQ-018 Write with write_en_i=1 while buffer_full_o=1 SHALL be discarded and drop_o SHALL be 1 the next cycle; this holds even if a pop occurs in the same cycle.
REQ-019 Pop SHALL occur iff grant_i && valid_o; the read pointer advances modulo DEPTH. grant_i while empty SHALL be ignored.
REQ-020 Simultaneous accepted write and pop SHALL leave count unchanged and move both pointers.
REQ-021 Latency: a flit written in cycle t SHALL appear on data_o/valid_o in cycle t+1 when the FIFO was empty.
REQ-022 data_o and packet_addr_o SHALL reflect the entry at the read pointer combinationally; their value is don't-care when valid_o=0.
REQ-023 request_o SHALL be 5'b0 when valid_o=0; otherwise it SHALL use XY routing on the head address: X>MY_X -> E; X<MY_X -> W; X==MY_X and Y>MY_Y -> N; Y<MY_Y -> S; both equal -> L.
REQ-024 Exactly one bit of request_o SHALL be set when valid_o=1.
REQ-025 request_o SHALL remain stable until the head is popped (no reordering, no dropping of the head).
REQ-026 Pointer wrap-around SHALL be seamless; FIFO order SHALL be preserved across wrap.

Reset
REQ-027 With rst=1 at a clock edge, count, both pointers and drop_o SHALL clear to 0; buffer_full_o=0, valid_o=0, request_o=0 in the following cycle.
REQ-028 rst SHALL override a concurrent write or grant; in-flight contents SHALL be discarded on mid-operation reset.
REQ-029 Storage array contents SHALL NOT require reset.

Verification
REQ-030 Reset, then write addr 8'h52 -> next cycle valid_o=1, request_o=5'b00100 (E), packet_addr_o=8'h52.
REQ-031 Sequential writes of heads 8'h22, 8'h23, 8'h21, 8'h12, one per cycle, with grant_i held 1 -> request_o sequence L(10000), N(00001), S(00010), W(01000), then 0.
REQ-032 Four writes with no grant -> buffer_full_o=1; fifth write -> drop_o pulses 1 cycle, count stays 4, contents unchanged.
REQ-033 Full FIFO with write_en_i=1 and grant_i=1 in the same cycle -> one pop, write dropped, drop_o=1, buffer_full_o=0 next cycle.
REQ-034 Ten writes/pops interleaved at count=2 steady state -> output order equals input order across pointer wrap; grant_i on empty -> no state change.
REQ-035 Reset asserted with 3 flits stored and grant_i=1 -> next cycle valid_o=0, request_o=0, buffer_full_o=0.
